// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix cell compute core: FSM encoding,
// operand-select codes and the accumulator width rule.
package matrix_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RDA  = 3'd1,
      RDB  = 3'd2,
      MAC  = 3'd3,
      WR   = 3'd4
   } state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // Wide enough that 2^max_width_len full-scale products cannot overflow.
   function automatic int acc_width(input int size_value, input int max_width_len);
      return 2 * size_value + max_width_len;
   endfunction

endpackage

// File: rtl/matrix_mac.sv
// Signed multiply-accumulate for one output cell, with optional output clamp
// selected by MATRIX_CELL_CORE_SAT_EN (accumulator itself is never clamped).
module matrix_mac
   import matrix_pkg::*;
#(
   parameter int sizeValue   = 8,
   parameter int maxWidthLen = 4,
   parameter int accWidth    = acc_width(sizeValue, maxWidthLen)
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  en,
   input  logic [sizeValue-1:0]  op_a,
   input  logic [sizeValue-1:0]  op_b,
   output logic [accWidth-1:0]   result
);

   logic signed [2*sizeValue-1:0] a_ext;
   logic signed [2*sizeValue-1:0] b_ext;
   logic signed [2*sizeValue-1:0] product;
   logic signed [accWidth-1:0]    product_ext;
   logic signed [accWidth-1:0]    acc_reg;

   assign a_ext       = {{sizeValue{op_a[sizeValue-1]}}, op_a};
   assign b_ext       = {{sizeValue{op_b[sizeValue-1]}}, op_b};
   assign product     = a_ext * b_ext;
   assign product_ext = {{(accWidth-2*sizeValue){product[2*sizeValue-1]}}, product};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_reg <= '0;
      end else if (clr) begin
         acc_reg <= '0;
      end else if (en) begin
         acc_reg <= acc_reg + product_ext;
      end
   end

`ifdef MATRIX_CELL_CORE_SAT_EN
   localparam logic signed [accWidth-1:0] SAT_MAX = accWidth'((1 << (sizeValue-1)) - 1);
   localparam logic signed [accWidth-1:0] SAT_MIN = ~SAT_MAX;

   always_comb begin
      if (acc_reg > SAT_MAX) begin
         result = SAT_MAX;
      end else if (acc_reg < SAT_MIN) begin
         result = SAT_MIN;
      end else begin
         result = acc_reg;
      end
   end
`else
   assign result = acc_reg;
`endif

endmodule

// File: rtl/matrix_cell_core.sv
// Responder-side compute core: fetches A[ry][k] and B[k][rx] over a shared read
// port, accumulates, and writes C[ry][rx]. Output clamp via MATRIX_CELL_CORE_SAT_EN.
module matrix_cell_core
   import matrix_pkg::*;
#(
   parameter int maxWidthLen = 4,
   parameter int sizeValue   = 8,
   parameter int coreId      = 0
)
(
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               startCore,
   input  logic [2:0]                         index,
   input  logic [maxWidthLen-1:0]             rx,
   input  logic [maxWidthLen-1:0]             ry,
   input  logic [maxWidthLen-1:0]             sizek,
   output logic                               rdy,
   output logic                               rd_req,
   output logic                               rd_sel,
   output logic [maxWidthLen-1:0]             rd_row,
   output logic [maxWidthLen-1:0]             rd_col,
   input  logic                               rd_ack,
   input  logic [sizeValue-1:0]               rd_data,
   output logic                               wr_req,
   output logic [maxWidthLen-1:0]             wr_row,
   output logic [maxWidthLen-1:0]             wr_col,
   output logic [2*sizeValue+maxWidthLen-1:0] wr_data,
   input  logic                               wr_ack
);

   localparam int ACC_W = acc_width(sizeValue, maxWidthLen);

   state_t                 state_reg;
   state_t                 state_next;
   logic [maxWidthLen-1:0] rx_reg;
   logic [maxWidthLen-1:0] ry_reg;
   logic [maxWidthLen-1:0] sizek_reg;
   logic [maxWidthLen-1:0] k_reg;
   logic [sizeValue-1:0]   op_a_reg;
   logic [sizeValue-1:0]   op_b_reg;
   logic [ACC_W-1:0]       mac_result;
   logic                   start_hit;
   logic                   last_term;

   assign start_hit = (state_reg == IDLE) && startCore && (index == 3'(coreId));
   assign last_term = (k_reg == sizek_reg);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_hit) state_next = RDA;
         RDA:     if (rd_ack) state_next = RDB;
         RDB:     if (rd_ack) state_next = MAC;
         MAC:     state_next = last_term ? WR : RDA;
         WR:      if (wr_ack) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Job coordinates are only captured in IDLE, so a start during a job cannot disturb it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_reg    <= '0;
         ry_reg    <= '0;
         sizek_reg <= '0;
         k_reg     <= '0;
         op_a_reg  <= '0;
         op_b_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_hit) begin
                  rx_reg    <= rx;
                  ry_reg    <= ry;
                  sizek_reg <= sizek;
                  k_reg     <= '0;
               end
            end
            RDA:     if (rd_ack) op_a_reg <= rd_data;
            RDB:     if (rd_ack) op_b_reg <= rd_data;
            MAC:     if (!last_term) k_reg <= k_reg + maxWidthLen'(1);
            default: ;
         endcase
      end
   end

   matrix_mac #(
      .sizeValue   (sizeValue),
      .maxWidthLen (maxWidthLen),
      .accWidth    (ACC_W)
   ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .clr    (start_hit),
      .en     (state_reg == MAC),
      .op_a   (op_a_reg),
      .op_b   (op_b_reg),
      .result (mac_result)
   );

   always_comb begin
      rdy     = 1'b0;
      rd_req  = 1'b0;
      rd_sel  = SEL_A;
      rd_row  = '0;
      rd_col  = '0;
      wr_req  = 1'b0;
      wr_row  = '0;
      wr_col  = '0;
      wr_data = '0;
      case (state_reg)
         IDLE: rdy = 1'b1;
         RDA: begin
            rd_req = 1'b1;
            rd_sel = SEL_A;
            rd_row = ry_reg;
            rd_col = k_reg;
         end
         RDB: begin
            rd_req = 1'b1;
            rd_sel = SEL_B;
            rd_row = k_reg;
            rd_col = rx_reg;
         end
         WR: begin
            wr_req  = 1'b1;
            wr_row  = ry_reg;
            wr_col  = rx_reg;
            wr_data = mac_result;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_matrix_cell_core.sv
// Randomised bench for matrix_cell_core against a dot-product reference model;
// honours MATRIX_CELL_CORE_SAT_EN when computing expected results.
module tb_matrix_cell_core;

   localparam int MW  = 4;
   localparam int SV  = 8;
   localparam int CID = 2;
   localparam int DW  = 2*SV + MW;
`ifdef MATRIX_CELL_CORE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   localparam longint SMAX = (64'sd1 <<< (SV-1)) - 1;
   localparam longint SMIN = -(64'sd1 <<< (SV-1));

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          startCore = 1'b0;
   logic [2:0]    index = '0;
   logic [MW-1:0] rx = '0, ry = '0, sizek = '0;
   logic          rdy, rd_req, rd_sel, rd_ack, wr_req, wr_ack;
   logic [MW-1:0] rd_row, rd_col, wr_row, wr_col;
   logic [SV-1:0] rd_data;
   logic [DW-1:0] wr_data;

   logic [SV-1:0] mem_a [16][16];
   logic [SV-1:0] mem_b [16][16];
   int            rd_wait = 0, wr_wait = 0, rd_cnt = 0, wr_cnt = 0;
   int            checks = 0, failures = 0;
   logic          job_active = 1'b0;
   logic [8:0]    rd_q[$];
   logic [MW-1:0] exp_wr_row, exp_wr_col;
   longint        exp_wr_data;
   longint        last_wr = 0;
   int            wr_count = 0;
   logic          hold_valid = 1'b0;
   logic [8:0]    hold_addr = '0;

   always #5 clk = ~clk;

   matrix_cell_core #(.maxWidthLen(MW), .sizeValue(SV), .coreId(CID)) dut (
      .clk(clk), .rst(rst), .startCore(startCore), .index(index),
      .rx(rx), .ry(ry), .sizek(sizek), .rdy(rdy),
      .rd_req(rd_req), .rd_sel(rd_sel), .rd_row(rd_row), .rd_col(rd_col),
      .rd_ack(rd_ack), .rd_data(rd_data),
      .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
      .wr_ack(wr_ack)
   );

   // Memory responder: acks after a programmable number of wait cycles.
   assign rd_ack  = rd_req && (rd_cnt >= rd_wait);
   assign wr_ack  = wr_req && (wr_cnt >= wr_wait);
   assign rd_data = rd_sel ? mem_b[rd_row][rd_col] : mem_a[rd_row][rd_col];

   always @(posedge clk) begin
      rd_cnt <= (rd_req && !rd_ack) ? rd_cnt + 1 : 0;
      wr_cnt <= (wr_req && !wr_ack) ? wr_cnt + 1 : 0;
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint model_cell(input int r, input int c, input int kmax);
      longint s = 0;
      for (int k = 0; k <= kmax; k++)
         s += longint'($signed(mem_a[r][k])) * longint'($signed(mem_b[k][c]));
      if (SAT) begin
         if (s > SMAX) s = SMAX;
         else if (s < SMIN) s = SMIN;
      end
      return s;
   endfunction

   // Compare process: every cycle, against the expected transaction stream.
   always @(negedge clk) begin
      if (!job_active) begin
         check("idle_rdy", longint'(rdy), 1);
         check("idle_rd_req", longint'(rd_req), 0);
         check("idle_wr_req", longint'(wr_req), 0);
      end
      if (rd_req) begin
         check("rd_busy_rdy", longint'(rdy), 0);
         if (hold_valid) check("rd_addr_hold", longint'({rd_sel, rd_row, rd_col}), longint'(hold_addr));
         if (rd_ack) begin
            hold_valid <= 1'b0;
            if (rd_q.size() == 0) check("rd_unexpected", longint'(rd_q.size()), 1);
            else check("rd_addr", longint'({rd_sel, rd_row, rd_col}), longint'(rd_q.pop_front()));
         end else begin
            hold_valid <= 1'b1;
            hold_addr  <= {rd_sel, rd_row, rd_col};
         end
      end else begin
         hold_valid <= 1'b0;
      end
      if (wr_req && wr_ack) begin
         check("wr_row", longint'(wr_row), longint'(exp_wr_row));
         check("wr_col", longint'(wr_col), longint'(exp_wr_col));
         check("wr_data", longint'($signed(wr_data)), exp_wr_data);
         check("wr_reads_done", longint'(rd_q.size()), 0);
         last_wr  <= longint'($signed(wr_data));
         wr_count <= wr_count + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int jrx, input int jry, input int jk);
      for (int k = 0; k <= jk; k++) begin
         rd_q.push_back({1'b0, MW'(jry), MW'(k)});
         rd_q.push_back({1'b1, MW'(k), MW'(jrx)});
      end
      exp_wr_row  = MW'(jry);
      exp_wr_col  = MW'(jrx);
      exp_wr_data = model_cell(jry, jrx, jk);
      job_active  = 1'b1;
      startCore   = 1'b1;
      index       = 3'(CID);
      rx          = MW'(jrx);
      ry          = MW'(jry);
      sizek       = MW'(jk);
      tick();
      startCore   = 1'b0;
   endtask

   task automatic finish_job(input bit poke, output int wr_cyc, output int rdy_cyc);
      int cyc = 1;
      int wc0 = wr_count;
      bit poked = 1'b0;
      wr_cyc  = -1;
      rdy_cyc = -1;
      while (cyc < 1000) begin
         if (wr_req && wr_cyc < 0) wr_cyc = cyc;
         if (rdy) begin
            rdy_cyc = cyc;
            break;
         end
         if (poke && !poked && rd_req && rd_sel) begin
            startCore = 1'b1;
            index     = 3'(CID);
            rx        = rx + MW'(1);
            ry        = ry + MW'(3);
            sizek     = sizek + MW'(2);
            poked     = 1'b1;
         end else begin
            startCore = 1'b0;
         end
         tick();
         cyc++;
      end
      startCore = 1'b0;
      check("job_timeout", longint'(rdy_cyc >= 0), 1);
      check("job_writes", longint'(wr_count - wc0), 1);
      job_active = 1'b0;
   endtask

   task automatic run_job(input int jrx, input int jry, input int jk, input int rw, input int ww,
                          input bit poke, output int wr_cyc, output int rdy_cyc);
      rd_wait = rw;
      wr_wait = ww;
      start_job(jrx, jry, jk);
      check("rdy_falls", longint'(rdy), 0);
      finish_job(poke, wr_cyc, rdy_cyc);
   endtask

   initial begin
      int wc, rc, kk, rw, ww, v;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) begin
            mem_a[r][c] = 8'($urandom);
            mem_b[r][c] = 8'($urandom);
         end

      // Reset values
      tick();
      check("rst_rdy", longint'(rdy), 1);
      check("rst_rd_req", longint'(rd_req), 0);
      check("rst_wr_req", longint'(wr_req), 0);
      check("rst_rd_sel", longint'(rd_sel), 0);
      check("rst_rd_addr", longint'({rd_row, rd_col}), 0);
      check("rst_wr_addr", longint'({wr_row, wr_col}), 0);
      check("rst_wr_data", longint'(wr_data), 0);
      rst = 1'b1;
      tick();

      // Basic two-term cell
      mem_a[1][0] = 8'sd3;  mem_a[1][1] = -8'sd2;
      mem_b[0][0] = 8'sd4;  mem_b[1][0] = 8'sd5;
      run_job(0, 1, 1, 0, 0, 1'b0, wc, rc);
      check("basic_wr_cycle", wc, 7);
      check("basic_rdy_cycle", rc, 8);
      check("basic_result", last_wr, 2);

      // Index mismatch
      startCore = 1'b1; index = 3'd3; rx = '0; ry = 4'd1; sizek = 4'd1;
      tick();
      startCore = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("mismatch_rdy", longint'(rdy), 1);
         check("mismatch_rd_req", longint'(rd_req), 0);
         tick();
      end

      // Read wait states, then write wait states
      run_job(0, 1, 1, 3, 0, 1'b0, wc, rc);
      check("rdwait_wr_cycle", wc, 19);
      check("rdwait_rdy_cycle", rc, 20);
      check("rdwait_result", last_wr, 2);
      run_job(0, 1, 1, 0, 2, 1'b0, wc, rc);
      check("wrwait_rdy_cycle", rc, 10);

      // Overflow / saturation
      for (int k = 0; k < 4; k++) begin
         mem_a[5][k] = 8'sd127;
         mem_b[k][6] = 8'sd127;
      end
      run_job(6, 5, 3, 0, 0, 1'b0, wc, rc);
      check("ovf_result", last_wr, SAT ? 127 : 64516);
      check("ovf_rdy_cycle", rc, 14);

      // Single term
      mem_a[7][0] = 8'h80;
      mem_b[0][9] = 8'h80;
      run_job(9, 7, 0, 0, 0, 1'b0, wc, rc);
      check("single_result", last_wr, SAT ? 127 : 16384);
      check("single_wr_cycle", wc, 4);
      check("single_rdy_cycle", rc, 5);

      // Busy start during RDB is ignored
      run_job(0, 1, 1, 0, 0, 1'b1, wc, rc);
      check("busy_result", last_wr, 2);
      check("busy_rdy_cycle", rc, 8);

      // Reset during MAC
      rd_wait = 0; wr_wait = 0;
      start_job(0, 1, 1);
      tick();
      tick();
      check("mac_outputs", longint'({rdy, rd_req, wr_req}), 0);
      job_active = 1'b0;
      rd_q.delete();
      rst = 1'b0;
      #1;
      check("rst_mac_rdy", longint'(rdy), 1);
      check("rst_mac_rd_req", longint'(rd_req), 0);
      tick();
      rst = 1'b1;
      tick();
      check("rst_mac_release_rdy", longint'(rdy), 1);

      // Reset while a read is waiting: req must drop without a clock edge
      rd_wait = 3;
      start_job(2, 3, 2);
      tick();
      check("rdwait_req_up", longint'(rd_req), 1);
      job_active = 1'b0;
      rd_q.delete();
      rst = 1'b0;
      #1;
      check("rst_async_rd_req", longint'(rd_req), 0);
      tick();
      rst = 1'b1;
      tick();

      run_job(0, 1, 1, 0, 0, 1'b0, wc, rc);
      check("post_rst_result", last_wr, 2);
      check("post_rst_rdy_cycle", rc, 8);

      // Randomised jobs
      for (int j = 0; j < 30; j++) begin
         for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
               mem_a[r][c] = 8'($urandom);
               mem_b[r][c] = 8'($urandom);
            end
         kk = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
         rw = int'($urandom_range(0, 2));
         ww = int'($urandom_range(0, 2));
         run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), kk, rw, ww,
                 1'($urandom_range(0, 1)), wc, rc);
         check("rand_wr_cycle", wc, 3*(kk+1) + 1 + 2*(kk+1)*rw);
         check("rand_rdy_cycle", rc, 3*(kk+1) + 2 + 2*(kk+1)*rw + ww);
         v = int'($urandom_range(0, 6));
         if (v >= CID) v++;
         startCore = 1'b1; index = 3'(v);
         tick();
         startCore = 1'b0;
         check("rand_mismatch_rd_req", longint'(rd_req), 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
